// File: rtl/traffic_pkg.sv
// Shared definitions for the N-direction traffic light controller.
//   - state_t   : FSM state encodings, also the value driven on the 2-bit
//                 state output (00 ALL_RED, 01 GREEN, 10 YELLOW; 11 illegal).
//   - MAX_DIR   : largest supported direction count.
//   - LAMPS_ON / LAMPS_OFF : lamp-vector constants, sliced to N_DIR by users.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10
    } state_t;

    localparam int MAX_DIR = 8;

    localparam logic [MAX_DIR-1:0] LAMPS_ON  = '1;
    localparam logic [MAX_DIR-1:0] LAMPS_OFF = '0;

endpackage

// File: rtl/traffic_light_controller_nway_rr.sv
// Combinational round-robin search for the next direction to serve.
// Ports:
//   pending     in  N_DIR          requesting directions (current owner masked)
//   cur_dir     in  $clog2(N_DIR)  direction currently owning the right of way
//   next_dir    out $clog2(N_DIR)  first requester after cur_dir, with wrap
//   any_pending out 1              at least one other direction is waiting
module rr_next_dir
    import traffic_pkg::*;
#(
    parameter int N_DIR = 4
) (
    input  logic [N_DIR-1:0]         pending,
    input  logic [$clog2(N_DIR)-1:0] cur_dir,
    output logic [$clog2(N_DIR)-1:0] next_dir,
    output logic                     any_pending
);

    localparam int DIR_W = $clog2(N_DIR);

    assign any_pending = |pending;

    // Scan cur_dir+1, cur_dir+2, ... modulo N_DIR; the first hit wins, so
    // a direction just served always goes to the back of the queue.
    always_comb begin
        int  idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        next_dir = cur_dir;
        for (int i = 1; i < N_DIR; i++) begin
            idx = int'(cur_dir) + i;
            if (idx >= N_DIR) begin
                idx = idx - N_DIR;
            end
            if (!found && pending[idx]) begin
                found    = 1'b1;
                next_dir = DIR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/traffic_light_controller_nway.sv
// N-direction traffic light controller. One direction is green at a time;
// the next one is chosen round-robin among directions with cars waiting.
// Phase lengths are counted in ticks of an internal clock prescaler.
// Ports:
//   clk        in  1              system clock
//   resetn     in  1              asynchronous active-low reset
//   car_sense  in  N_DIR          per-direction car present (sync level)
//   red        out N_DIR          red lamp per direction
//   yellow     out N_DIR          yellow lamp per direction
//   green      out N_DIR          green lamp per direction
//   cur_dir    out $clog2(N_DIR)  direction owning (or last owning) right of way
//   state      out 2              00 ALL_RED, 01 GREEN, 10 YELLOW
//   phase_cnt  out CNT_W          ticks elapsed in the current phase
module traffic_light_controller_nway
    import traffic_pkg::*;
#(
    parameter int N_DIR     = 4,
    parameter int TICK_DIV  = 100000000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N_DIR-1:0]         car_sense,
    output logic [N_DIR-1:0]         red,
    output logic [N_DIR-1:0]         yellow,
    output logic [N_DIR-1:0]         green,
    output logic [$clog2(N_DIR)-1:0] cur_dir,
    output logic [1:0]               state,
    output logic [CNT_W-1:0]         phase_cnt
);

    localparam int DIR_W = $clog2(N_DIR);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
    localparam logic [N_DIR-1:0] DIR_ONE     = N_DIR'(1);

    state_t             st_q;
    state_t             st_d;
    logic [DIR_W-1:0]   next_dir_q;
    logic [DIR_W-1:0]   next_dir_d;
    logic [DIR_W-1:0]   cur_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [PRE_W-1:0]   presc;
    logic               tick;
    logic [N_DIR-1:0]   pending;
    logic [DIR_W-1:0]   rr_dir;
    logic               any_pending;
    logic               own_sense;
    logic [N_DIR-1:0]   red_d;
    logic [N_DIR-1:0]   yellow_d;
    logic [N_DIR-1:0]   green_d;

    assign state = st_q;

    // Prescaler: with TICK_DIV=1 presc stays at 0 and tick is constantly 1.
    assign tick = (presc == PRE_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign pending   = car_sense & ~(DIR_ONE << cur_dir);
    assign own_sense = car_sense[cur_dir];

    rr_next_dir #(
        .N_DIR (N_DIR)
    ) u_rr (
        .pending     (pending),
        .cur_dir     (cur_dir),
        .next_dir    (rr_dir),
        .any_pending (any_pending)
    );

    // Next-state logic. next_dir is only written on GREEN->YELLOW, which
    // freezes the choice through YELLOW and ALL_RED regardless of sensors.
    always_comb begin
        st_d       = st_q;
        cur_d      = cur_dir;
        next_dir_d = next_dir_q;
        cnt_d      = phase_cnt;
        case (st_q)
            ST_ALL_RED: begin
                if (tick && phase_cnt >= ALLRED_LAST) begin
                    st_d  = ST_GREEN;
                    cur_d = next_dir_q;
                end
            end
            ST_GREEN: begin
                if (tick && any_pending &&
                    ((!own_sense && phase_cnt >= GMIN_LAST) || phase_cnt >= GMAX_LAST)) begin
                    st_d       = ST_YELLOW;
                    next_dir_d = rr_dir;
                end
            end
            ST_YELLOW: begin
                if (tick && phase_cnt >= YELLOW_LAST) begin
                    st_d = ST_ALL_RED;
                end
            end
            default: begin
                // Encoding 11 is unreachable in normal operation; fall back
                // to the safe all-red state.
                st_d = ST_ALL_RED;
            end
        endcase

        // Idle green (nobody else waiting) parks the counter at GREEN_MAX-1
        // so a later request yields immediately after GREEN_MIN is satisfied.
        if (st_d != st_q) begin
            cnt_d = '0;
        end else if (tick && !(st_q == ST_GREEN && phase_cnt >= GMAX_LAST)) begin
            cnt_d = phase_cnt + 1'b1;
        end
    end

    // Lamps are decoded from the next state so they change on the same edge
    // as the state register.
    always_comb begin
        red_d    = LAMPS_ON[N_DIR-1:0];
        yellow_d = LAMPS_OFF[N_DIR-1:0];
        green_d  = LAMPS_OFF[N_DIR-1:0];
        case (st_d)
            ST_GREEN: begin
                green_d[cur_d] = 1'b1;
                red_d[cur_d]   = 1'b0;
            end
            ST_YELLOW: begin
                yellow_d[cur_d] = 1'b1;
                red_d[cur_d]    = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q       <= ST_ALL_RED;
            cur_dir    <= '0;
            next_dir_q <= '0;
            phase_cnt  <= '0;
            red        <= LAMPS_ON[N_DIR-1:0];
            yellow     <= LAMPS_OFF[N_DIR-1:0];
            green      <= LAMPS_OFF[N_DIR-1:0];
        end else begin
            st_q       <= st_d;
            cur_dir    <= cur_d;
            next_dir_q <= next_dir_d;
            phase_cnt  <= cnt_d;
            red        <= red_d;
            yellow     <= yellow_d;
            green      <= green_d;
        end
    end

endmodule

// File: tb/tb_traffic_light_controller_nway.sv
module tb_traffic_light_controller_nway;

    localparam logic [1:0] S_AR = 2'b00;
    localparam logic [1:0] S_G  = 2'b01;
    localparam logic [1:0] S_Y  = 2'b10;

    logic       clk;
    logic       resetn_a, resetn_b;
    logic [3:0] car_a, car_b;
    logic [3:0] red_a, yellow_a, green_a;
    logic [3:0] red_b, yellow_b, green_b;
    logic [1:0] cur_a, cur_b;
    logic [1:0] state_a, state_b;
    logic [7:0] cnt_a, cnt_b;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic mon_en  = 1'b0;

    traffic_light_controller_nway #(
        .N_DIR(4), .TICK_DIV(1), .GREEN_MIN(4), .GREEN_MAX(8),
        .YELLOW_T(2), .ALLRED_T(1), .CNT_W(8)
    ) dut_a (
        .clk(clk), .resetn(resetn_a), .car_sense(car_a),
        .red(red_a), .yellow(yellow_a), .green(green_a),
        .cur_dir(cur_a), .state(state_a), .phase_cnt(cnt_a)
    );

    traffic_light_controller_nway #(
        .N_DIR(4), .TICK_DIV(4), .GREEN_MIN(4), .GREEN_MAX(8),
        .YELLOW_T(2), .ALLRED_T(1), .CNT_W(8)
    ) dut_b (
        .clk(clk), .resetn(resetn_b), .car_sense(car_b),
        .red(red_b), .yellow(yellow_b), .green(green_b),
        .cur_dir(cur_b), .state(state_b), .phase_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_a();
        resetn_a = 1'b0;
        car_a    = 4'b0000;
        step_n(2);
        resetn_a = 1'b1;
    endtask

    // Counts sampled cycles while the chosen DUT stays in state st.
    task automatic run_phase(input int sel, input logic [1:0] st, input int limit, output int n);
        n = 0;
        while (((sel == 0) ? state_a : state_b) == st && n < limit) begin
            n++;
            step();
        end
    endtask

    // Lamp invariants on both instances every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            int bad_a, bad_b, nr_a, nr_b;
            bad_a = 0; bad_b = 0; nr_a = 0; nr_b = 0;
            for (int d = 0; d < 4; d++) begin
                if (int'(red_a[d]) + int'(yellow_a[d]) + int'(green_a[d]) != 1) bad_a++;
                if (int'(red_b[d]) + int'(yellow_b[d]) + int'(green_b[d]) != 1) bad_b++;
                if (!red_a[d]) nr_a++;
                if (!red_b[d]) nr_b++;
            end
            total_cnt++;
            if (bad_a != 0 || nr_a > 1)
                $display("FAIL lamp_invariant_a t=%0t r=%b y=%b g=%b", $time, red_a, yellow_a, green_a);
            else
                pass_cnt++;
            total_cnt++;
            if (bad_b != 0 || nr_b > 1)
                $display("FAIL lamp_invariant_b t=%0t r=%b y=%b g=%b", $time, red_b, yellow_b, green_b);
            else
                pass_cnt++;
        end
    end

    task automatic test_reset();
        step_n(2);
        mon_en = 1'b1;
        total_cnt++;
        if ({red_a, yellow_a, green_a} !== {4'b1111, 4'b0000, 4'b0000})
            $display("FAIL reset_lamps got r=%b y=%b g=%b want r=1111 y=0000 g=0000", red_a, yellow_a, green_a);
        else pass_cnt++;
        total_cnt++;
        if ({state_a, cur_a, cnt_a} !== {2'b00, 2'd0, 8'd0})
            $display("FAIL reset_regs got st=%b dir=%0d cnt=%0d want st=00 dir=0 cnt=0", state_a, cur_a, cnt_a);
        else pass_cnt++;
        resetn_a = 1'b1;
        #1;
        total_cnt++;
        if (state_a !== S_AR)
            $display("FAIL release_allred got st=%b want 00", state_a);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({state_a, green_a, red_a, cur_a, cnt_a} !== {S_G, 4'b0001, 4'b1110, 2'd0, 8'd0})
            $display("FAIL first_green got st=%b g=%b r=%b dir=%0d cnt=%0d want st=01 g=0001 r=1110 dir=0 cnt=0",
                     state_a, green_a, red_a, cur_a, cnt_a);
        else pass_cnt++;
    endtask

    task automatic test_idle_saturate();
        step_n(50);
        total_cnt++;
        if ({state_a, green_a, cnt_a} !== {S_G, 4'b0001, 8'd7})
            $display("FAIL idle_saturate got st=%b g=%b cnt=%0d want st=01 g=0001 cnt=7", state_a, green_a, cnt_a);
        else pass_cnt++;
    endtask

    task automatic test_yield_min();
        int n;
        reset_a();
        step();
        car_a = 4'b0100;
        run_phase(0, S_G, 100, n);
        total_cnt++;
        if (n !== 4) $display("FAIL yield_min_green_len got %0d want 4", n); else pass_cnt++;
        total_cnt++;
        if ({yellow_a, red_a} !== {4'b0001, 4'b1110})
            $display("FAIL yield_min_yellow got y=%b r=%b want y=0001 r=1110", yellow_a, red_a);
        else pass_cnt++;
        // Requester drops and another appears during yellow: choice stays 2.
        car_a = 4'b0010;
        run_phase(0, S_Y, 100, n);
        total_cnt++;
        if (n !== 2) $display("FAIL yield_min_yellow_len got %0d want 2", n); else pass_cnt++;
        total_cnt++;
        if (red_a !== 4'b1111) $display("FAIL yield_min_allred got r=%b want 1111", red_a); else pass_cnt++;
        run_phase(0, S_AR, 100, n);
        total_cnt++;
        if (n !== 1) $display("FAIL yield_min_allred_len got %0d want 1", n); else pass_cnt++;
        total_cnt++;
        if ({green_a, cur_a} !== {4'b0100, 2'd2})
            $display("FAIL frozen_next_dir got g=%b dir=%0d want g=0100 dir=2", green_a, cur_a);
        else pass_cnt++;
        run_phase(0, S_G, 100, n);
        total_cnt++;
        if (n !== 4) $display("FAIL dropped_req_green_len got %0d want 4", n); else pass_cnt++;
        total_cnt++;
        if (yellow_a !== 4'b0100) $display("FAIL dropped_req_yellow got y=%b want 0100", yellow_a); else pass_cnt++;
    endtask

    task automatic test_forced_yield();
        int n;
        reset_a();
        step();
        car_a = 4'b0011;
        run_phase(0, S_G, 100, n);
        total_cnt++;
        if (n !== 8) $display("FAIL forced_green_len got %0d want 8", n); else pass_cnt++;
        run_phase(0, S_Y, 100, n);
        total_cnt++;
        if (n !== 2) $display("FAIL forced_yellow_len got %0d want 2", n); else pass_cnt++;
        run_phase(0, S_AR, 100, n);
        total_cnt++;
        if ({green_a, cur_a} !== {4'b0010, 2'd1})
            $display("FAIL forced_next got g=%b dir=%0d want g=0010 dir=1", green_a, cur_a);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int n;
        reset_a();
        step();
        car_a = 4'b0010;
        run_phase(0, S_G, 100, n);
        run_phase(0, S_Y, 100, n);
        run_phase(0, S_AR, 100, n);
        total_cnt++;
        if (cur_a !== 2'd1) $display("FAIL rr_reach_dir1 got dir=%0d want 1", cur_a); else pass_cnt++;
        car_a = 4'b1001;
        run_phase(0, S_G, 100, n);
        total_cnt++;
        if (n !== 4) $display("FAIL rr_dir1_green_len got %0d want 4", n); else pass_cnt++;
        run_phase(0, S_Y, 100, n);
        run_phase(0, S_AR, 100, n);
        total_cnt++;
        if ({green_a, cur_a} !== {4'b1000, 2'd3})
            $display("FAIL rr_after_1 got g=%b dir=%0d want g=1000 dir=3", green_a, cur_a);
        else pass_cnt++;
        run_phase(0, S_G, 100, n);
        total_cnt++;
        if (n !== 8) $display("FAIL rr_dir3_green_len got %0d want 8", n); else pass_cnt++;
        run_phase(0, S_Y, 100, n);
        run_phase(0, S_AR, 100, n);
        total_cnt++;
        if ({green_a, cur_a} !== {4'b0001, 2'd0})
            $display("FAIL rr_wrap got g=%b dir=%0d want g=0001 dir=0", green_a, cur_a);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int n;
        reset_a();
        step();
        car_a = 4'b0100;
        run_phase(0, S_G, 100, n);
        total_cnt++;
        if (state_a !== S_Y) $display("FAIL async_pre_yellow got st=%b want 10", state_a); else pass_cnt++;
        resetn_a = 1'b0;
        #2;
        total_cnt++;
        if ({red_a, yellow_a, green_a, state_a, cur_a} !== {4'b1111, 4'b0000, 4'b0000, 2'b00, 2'd0})
            $display("FAIL async_reset got r=%b y=%b g=%b st=%b dir=%0d want r=1111 y=0000 g=0000 st=00 dir=0",
                     red_a, yellow_a, green_a, state_a, cur_a);
        else pass_cnt++;
        step_n(2);
        car_a    = 4'b0000;
        resetn_a = 1'b1;
        step();
        total_cnt++;
        if ({green_a, cur_a} !== {4'b0001, 2'd0})
            $display("FAIL async_restart got g=%b dir=%0d want g=0001 dir=0", green_a, cur_a);
        else pass_cnt++;
    endtask

    task automatic test_tick_div();
        int n;
        car_b    = 4'b0000;
        resetn_b = 1'b1;
        run_phase(1, S_AR, 200, n);
        total_cnt++;
        if (n !== 4) $display("FAIL tdiv_first_allred_len got %0d want 4", n); else pass_cnt++;
        total_cnt++;
        if (green_b !== 4'b0001) $display("FAIL tdiv_first_green got g=%b want 0001", green_b); else pass_cnt++;
        car_b = 4'b0100;
        run_phase(1, S_G, 200, n);
        total_cnt++;
        if (n !== 16) $display("FAIL tdiv_green_len got %0d want 16", n); else pass_cnt++;
        run_phase(1, S_Y, 200, n);
        total_cnt++;
        if (n !== 8) $display("FAIL tdiv_yellow_len got %0d want 8", n); else pass_cnt++;
        run_phase(1, S_AR, 200, n);
        total_cnt++;
        if (n !== 4) $display("FAIL tdiv_allred_len got %0d want 4", n); else pass_cnt++;
        total_cnt++;
        if ({green_b, cur_b} !== {4'b0100, 2'd2})
            $display("FAIL tdiv_next got g=%b dir=%0d want g=0100 dir=2", green_b, cur_b);
        else pass_cnt++;
    endtask

    initial begin
        resetn_a = 1'b0;
        resetn_b = 1'b0;
        car_a    = 4'b0000;
        car_b    = 4'b0000;
        test_reset();
        test_idle_saturate();
        test_yield_min();
        test_forced_yield();
        test_round_robin();
        test_async_reset();
        test_tick_div();
        step_n(2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/traffic_light_controller_nway.md
Name: traffic_light_controller_nway

Overview:
- Parametrised N-direction traffic light controller. Successor to the two-street (A/B) controller.
- Serves one green direction at a time, selected by round-robin among directions whose car sensors are asserted.
- Phase durations (min/max green, yellow, all-red) are parameters, counted in ticks from an internal clock prescaler.
- Sits at the top of the intersection design, driving lamp outputs directly.

Parameters:
- N_DIR, 4, number of directions (2..8).
- TICK_DIV, 100000000, clk cycles per tick (1 for simulation).
- GREEN_MIN, 5, minimum green ticks before yielding.
- GREEN_MAX, 20, maximum green ticks while own sensor asserted and others waiting.
- YELLOW_T, 3, yellow ticks.
- ALLRED_T, 1, all-red clearance ticks.
- CNT_W, 8, phase counter width; must hold GREEN_MAX-1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- car_sense  in  N_DIR  per-direction car present; level, synchronous to clk.
- red  out  N_DIR  red lamp per direction.
- yellow  out  N_DIR  yellow lamp per direction.
- green  out  N_DIR  green lamp per direction.
- cur_dir  out  $clog2(N_DIR)  direction currently owning (or last owning) the right of way.
- state  out  2  FSM state: 00 ALL_RED, 01 GREEN, 10 YELLOW.
- phase_cnt  out  CNT_W  ticks elapsed in current phase.

Behaviour:
- Tick: prescaler counts 0..TICK_DIV-1; tick=1 for one cycle when it reaches TICK_DIV-1, then wraps. TICK_DIV=1 means tick every cycle.
- phase_cnt clears to 0 on every state change. It increments only on tick.
- A phase of duration D exits on the tick where phase_cnt==D-1. The phase therefore lasts exactly D ticks.
- Async reset (resetn=0), applied immediately:
  - state=ALL_RED, cur_dir=0, next_dir=0, phase_cnt=0, prescaler=0.
  - red=all ones, yellow=0, green=0.
- Lamps are registered from state/cur_dir:
  - GREEN: green[cur_dir]=1.
  - YELLOW: yellow[cur_dir]=1.
  - All other directions red. Exactly one lamp per direction at all times. At most one direction non-red.
- pending = car_sense with bit cur_dir masked off.
- ALL_RED: on tick with phase_cnt==ALLRED_T-1, cur_dir<=next_dir and go to GREEN.
- GREEN, evaluated on tick:
  - If pending==0: stay GREEN indefinitely. phase_cnt saturates at GREEN_MAX-1.
  - Else if car_sense[cur_dir]==0 and phase_cnt>=GREEN_MIN-1: go to YELLOW.
  - Else if phase_cnt>=GREEN_MAX-1: go to YELLOW (forced yield).
  - On entering YELLOW: next_dir <= first set bit of pending, searching cur_dir+1, cur_dir+2, … with wrap modulo N_DIR.
- YELLOW: on tick with phase_cnt==YELLOW_T-1, go to ALL_RED.
- next_dir is frozen from YELLOW entry until the next GREEN. Sensor changes during YELLOW/ALL_RED do not alter it.
- If the requester drops before green, its green is still served (GREEN_MIN applies, then normal rules).
- Simultaneous requests: resolved by round-robin order only; there is no fixed priority.
- Reset mid-operation: lamps go all red within the same cycle. Restart at direction 0 after ALLRED_T ticks.
- After reset release: first green on dir 0 after ALLRED_T ticks.
- Illegal state encoding 11: recover to ALL_RED on the next clk.

Decomposition:
- Package traffic_pkg holds:
  - state encodings ST_ALL_RED / ST_GREEN / ST_YELLOW.
  - lamp-vector helper constants.
- One sub-module, rr_next_dir: combinational round-robin search.
  - Inputs: pending[N_DIR], cur_dir.
  - Outputs: next_dir, any_pending.
- Top holds the prescaler, FSM, phase counter and lamp registers.

Test Plan:
All scenarios use N_DIR=4, TICK_DIV=1, GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1 unless noted.
1. Reset release, car_sense=0 -> ALL_RED for 1 cycle, then green=0001, red=1110. Hold for 50 cycles; phase_cnt saturates at 7.
2. Dir 0 green, car_sense=0100 held -> green0 lasts 4 cycles from entry, yellow=0001 for 2, red=1111 for 1, then green=0100, cur_dir=2.
3. Dir 0 green, car_sense=0011 -> green0 held the full 8 cycles (forced yield), then yellow; next green=0010.
4. Round-robin: cur_dir=1, car_sense=1001 -> next dir 3. Then cur_dir=3 with car_sense=1001 -> next dir 0. Dir 0 is never skipped.
5. Assert resetn=0 mid-YELLOW -> red=1111, yellow=0, green=0 with no clock edge. Release -> green dir 0 after 1 tick.
6. TICK_DIV=4, scenario 2 stimulus -> green 16, yellow 8, all-red 4 cycles. Monitor: exactly one lamp per direction and ≤1 non-red direction, checked every cycle.
